// File: rtl/sme_host.sv
// sme_host: initiator-side driver for the string-matching engine.
// Buffers one string and several patterns, then streams them and collects results.
module sme_host #(
   parameter int MAX_STR     = 32,
   parameter int MAX_PAT_LEN = 8,
   parameter int NUM_PAT     = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       str_wr,
   input  logic [7:0]                 str_data,
   input  logic                       pat_wr,
   input  logic [7:0]                 pat_data,
   input  logic                       pat_last,
   input  logic                       clear,
   input  logic                       start,
   output logic [7:0]                 chardata,
   output logic                       isstring,
   output logic                       ispattern,
   input  logic                       match,
   input  logic [4:0]                 match_index,
   input  logic                       valid,
   output logic                       res_valid,
   output logic                       res_match,
   output logic [4:0]                 res_index,
   output logic [$clog2(NUM_PAT)-1:0] res_pid,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam int SW  = $clog2(MAX_STR + 1);
   localparam int SAW = $clog2(MAX_STR);
   localparam int LW  = $clog2(MAX_PAT_LEN + 1);
   localparam int PAW = $clog2(MAX_PAT_LEN);
   localparam int CW  = $clog2(NUM_PAT + 1);
   localparam int PW  = $clog2(NUM_PAT);
   localparam int TW  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STR,
      S_PAT,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                      state_q;
   logic [7:0]                  str_mem [MAX_STR];
   logic [7:0]                  pat_mem [NUM_PAT][MAX_PAT_LEN];
   logic [SW-1:0]               str_len_q;
   logic [CW-1:0]               pat_cnt_q;
   logic [NUM_PAT-1:0][LW-1:0]  pat_len_q;
   logic [SW-1:0]               idx_q;
   logic [PW-1:0]               pid_q;
   logic [TW-1:0]               tmo_q;

   logic          ld_en;
   logic          str_ok_d;
   logic          str_ovf_d;
   logic          pat_room_d;
   logic [PW-1:0] cur_d;
   logic          pat_ok_d;
   logic          pat_ovf_d;
   logic          pat_close_d;

   // Load-side decode: which buffer writes are accepted, dropped or close a pattern
   always_comb begin
      ld_en       = (state_q == S_IDLE) && !start && !clear;
      cur_d       = pat_cnt_q[PW-1:0];
      str_ok_d    = ld_en && str_wr && (str_len_q < SW'(MAX_STR));
      str_ovf_d   = ld_en && str_wr && !str_ok_d;
      pat_room_d  = pat_cnt_q < CW'(NUM_PAT);
      pat_ok_d    = ld_en && pat_wr && pat_room_d &&
                    (pat_len_q[cur_d] < LW'(MAX_PAT_LEN));
      pat_ovf_d   = ld_en && pat_wr && !pat_ok_d;
      pat_close_d = ld_en && pat_wr && pat_last && pat_room_d;
   end

   // Character storage; contents are only meaningful below the tracked lengths
   always_ff @(posedge clk) begin
      if (str_ok_d)
         str_mem[str_len_q[SAW-1:0]] <= str_data;
      if (pat_ok_d)
         pat_mem[cur_d][pat_len_q[cur_d][PAW-1:0]] <= pat_data;
   end

   // Job FSM: buffer bookkeeping, streaming, result capture and timeout
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         str_len_q <= '0;
         pat_cnt_q <= '0;
         pat_len_q <= '0;
         idx_q     <= '0;
         pid_q     <= '0;
         tmo_q     <= '0;
         chardata  <= '0;
         isstring  <= 1'b0;
         ispattern <= 1'b0;
         res_valid <= 1'b0;
         res_match <= 1'b0;
         res_index <= '0;
         res_pid   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         done      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (str_len_q == '0 || pat_cnt_q == '0) begin
                     err  <= 1'b1;
                     done <= 1'b1;
                  end else begin
                     err      <= 1'b0;
                     busy     <= 1'b1;
                     isstring <= 1'b1;
                     chardata <= str_mem[0];
                     idx_q    <= SW'(1);
                     pid_q    <= '0;
                     state_q  <= S_STR;
                  end
               end else if (clear) begin
                  str_len_q <= '0;
                  pat_cnt_q <= '0;
                  pat_len_q <= '0;
               end else begin
                  if (str_ok_d)
                     str_len_q <= str_len_q + SW'(1);
                  if (pat_ok_d)
                     pat_len_q[cur_d] <= pat_len_q[cur_d] + LW'(1);
                  if (pat_close_d)
                     pat_cnt_q <= pat_cnt_q + CW'(1);
                  if (str_ovf_d || pat_ovf_d)
                     err <= 1'b1;
               end
            end
            S_STR: begin
               if (idx_q < str_len_q) begin
                  chardata <= str_mem[idx_q[SAW-1:0]];
                  idx_q    <= idx_q + SW'(1);
               end else begin
                  // pattern 0 must follow the string with no idle gap
                  isstring  <= 1'b0;
                  ispattern <= 1'b1;
                  chardata  <= pat_mem[0][0];
                  idx_q     <= SW'(1);
                  state_q   <= S_PAT;
               end
            end
            S_PAT: begin
               if (idx_q < SW'(pat_len_q[pid_q])) begin
                  chardata <= pat_mem[pid_q][idx_q[PAW-1:0]];
                  idx_q    <= idx_q + SW'(1);
               end else begin
                  ispattern <= 1'b0;
                  chardata  <= '0;
                  tmo_q     <= '0;
                  state_q   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (valid) begin
                  res_valid <= 1'b1;
                  res_match <= match;
                  res_index <= match_index;
                  res_pid   <= pid_q;
                  if (CW'(pid_q) + CW'(1) < pat_cnt_q) begin
                     pid_q     <= pid_q + PW'(1);
                     ispattern <= 1'b1;
                     chardata  <= pat_mem[pid_q + PW'(1)][0];
                     idx_q     <= SW'(1);
                     state_q   <= S_PAT;
                  end else begin
                     state_q <= S_DONE;
                  end
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  err     <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            S_DONE: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
